// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 hex matrix keypad scanner with debounce
// and an 8-digit shift buffer that feeds the seven-segment display.
module keypad_scanner #(
    parameter int scan_speed      = 16,
    parameter int debounce_cycles = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    input  logic       clear,
    output logic [3:0] col,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_held,
    output logic [3:0] digits [0:7]
);

    localparam int DW = $clog2(debounce_cycles + 1);

    localparam logic [DW-1:0] DEB_ONE  = DW'(1);
    localparam logic [DW-1:0] DEB_LAST = DW'(debounce_cycles - 1);
    localparam logic [DW-1:0] DEB_MAX  = DW'(debounce_cycles);

    localparam logic [scan_speed-1:0] DWELL_ONE = scan_speed'(1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t                state_q,     state_d;
    logic [scan_speed-1:0] dwell_q,     dwell_d;
    logic [1:0]            col_idx_q,   col_idx_d;
    logic [1:0]            row_idx_q,   row_idx_d;
    logic [DW-1:0]         deb_q,       deb_d;
    logic                  key_valid_q, key_valid_d;
    logic [3:0]            key_code_q,  key_code_d;
    logic [3:0]            digits_q [0:7];
    logic [3:0]            digits_d [0:7];

    logic [3:0] sync1_q;
    logic [3:0] rs_q;

    logic       hit;
    logic [1:0] hit_idx;
    logic       match;
    logic       all_high;
    logic       dwell_last;
    logic       accept;
    logic [DW-1:0] deb_inc;

    // Hex value printed on each key, indexed by row and column.
    function automatic logic [3:0] key_map(
        input logic [1:0] r,
        input logic [1:0] c
    );
        logic [3:0] v;
        case ({r, c})
            4'b00_00: v = 4'h1;
            4'b00_01: v = 4'h2;
            4'b00_10: v = 4'h3;
            4'b00_11: v = 4'hA;
            4'b01_00: v = 4'h4;
            4'b01_01: v = 4'h5;
            4'b01_10: v = 4'h6;
            4'b01_11: v = 4'hB;
            4'b10_00: v = 4'h7;
            4'b10_01: v = 4'h8;
            4'b10_10: v = 4'h9;
            4'b10_11: v = 4'hC;
            4'b11_00: v = 4'h0;
            4'b11_01: v = 4'hF;
            4'b11_10: v = 4'hE;
            default:  v = 4'hD;
        endcase
        return v;
    endfunction

    // Two-flop synchronizer for the asynchronous row lines.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 4'h0;
            rs_q    <= 4'h0;
        end else begin
            sync1_q <= row;
            rs_q    <= sync1_q;
        end
    end

    // Find which single row is pulled low; ghosted patterns are not a hit.
    always_comb begin
        hit     = 1'b0;
        hit_idx = 2'd0;
        case (rs_q)
            4'b1110: begin hit = 1'b1; hit_idx = 2'd0; end
            4'b1101: begin hit = 1'b1; hit_idx = 2'd1; end
            4'b1011: begin hit = 1'b1; hit_idx = 2'd2; end
            4'b0111: begin hit = 1'b1; hit_idx = 2'd3; end
            default: begin hit = 1'b0; hit_idx = 2'd0; end
        endcase
    end

    assign match      = (rs_q == ~(4'b0001 << row_idx_q));
    assign all_high   = (rs_q == 4'hF);
    assign dwell_last = (dwell_q == '1);
    assign deb_inc    = (deb_q == DEB_MAX) ? deb_q : deb_q + DEB_ONE;

    // Scan / debounce / hold / release sequencing.
    always_comb begin
        state_d   = state_q;
        dwell_d   = '0;
        col_idx_d = col_idx_q;
        row_idx_d = row_idx_q;
        deb_d     = deb_q;
        accept    = 1'b0;
        case (state_q)
            SCAN: begin
                dwell_d = dwell_q + DWELL_ONE;
                if (dwell_last) begin
                    if (hit) begin
                        row_idx_d = hit_idx;
                        deb_d     = '0;
                        state_d   = DEBOUNCE;
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end
            end
            DEBOUNCE: begin
                if (!match) begin
                    deb_d     = '0;
                    col_idx_d = col_idx_q + 2'd1;
                    state_d   = SCAN;
                end else if (deb_q == DEB_LAST) begin
                    deb_d   = deb_inc;
                    accept  = 1'b1;
                    state_d = HELD;
                end else begin
                    deb_d = deb_inc;
                end
            end
            HELD: begin
                if (all_high) begin
                    deb_d   = '0;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (!all_high) begin
                    deb_d   = '0;
                    state_d = HELD;
                end else if (deb_q == DEB_LAST) begin
                    deb_d     = '0;
                    col_idx_d = col_idx_q + 2'd1;
                    state_d   = SCAN;
                end else begin
                    deb_d = deb_inc;
                end
            end
            default: begin
                state_d = SCAN;
            end
        endcase
    end

    // Key outputs and digit buffer; clear beats a same-cycle shift.
    always_comb begin
        key_valid_d = accept;
        key_code_d  = key_code_q;
        for (int i = 0; i < 8; i++) begin
            digits_d[i] = digits_q[i];
        end
        if (accept) begin
            key_code_d = key_map(row_idx_q, col_idx_q);
        end
        if (clear) begin
            for (int i = 0; i < 8; i++) begin
                digits_d[i] = 4'h0;
            end
        end else if (accept) begin
            for (int i = 7; i > 0; i--) begin
                digits_d[i] = digits_q[i-1];
            end
            digits_d[0] = key_map(row_idx_q, col_idx_q);
        end
    end

    // State, counter and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SCAN;
            dwell_q     <= '0;
            col_idx_q   <= 2'd0;
            row_idx_q   <= 2'd0;
            deb_q       <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'h0;
            for (int i = 0; i < 8; i++) begin
                digits_q[i] <= 4'h0;
            end
        end else begin
            state_q     <= state_d;
            dwell_q     <= dwell_d;
            col_idx_q   <= col_idx_d;
            row_idx_q   <= row_idx_d;
            deb_q       <= deb_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            for (int i = 0; i < 8; i++) begin
                digits_q[i] <= digits_d[i];
            end
        end
    end

    assign col       = ~(4'b0001 << col_idx_q);
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign key_held  = (state_q == HELD) || (state_q == RELEASE);
    assign digits    = digits_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: keypad matrix model driving the scanner,
// expected key events queued by stimulus and checked by a monitor.
module tb_keypad_scanner;

    localparam int SS = 2;
    localparam int DC = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] row;
    logic       clear;
    logic [3:0] col;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_held;
    logic [3:0] digits [0:7];

    keypad_scanner #(
        .scan_speed      (SS),
        .debounce_cycles (DC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .row       (row),
        .clear     (clear),
        .col       (col),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_held  (key_held),
        .digits    (digits)
    );

    always #5 clk = ~clk;

    // keypad model: a pressed key shorts its row to its column
    logic       key_dn;
    logic [1:0] key_r;
    logic [1:0] key_c;
    logic       ovr_en;
    logic [3:0] ovr;

    always_comb begin
        row = 4'hF;
        if (ovr_en) begin
            row = ovr;
        end else if (key_dn && !col[key_c]) begin
            row[key_r] = 1'b0;
        end
    end

    logic [31:0] dut_digs;
    always_comb begin
        dut_digs = '0;
        for (int i = 0; i < 8; i++) begin
            dut_digs[4*i +: 4] = digits[i];
        end
    end

    typedef struct packed {
        logic [3:0]  code;
        logic [31:0] digs;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mbuf;
    logic [3:0]  kmap [16];
    int          checks;
    int          errors;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // monitor: every key_valid pulse must match the next queued event
    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got code %h expected no pulse",
                         key_code);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("key_code", 32'(key_code), 32'(e.code));
                chk("digits", dut_digs, e.digs);
            end
        end
    end

    task automatic expect_key(input int r, input int c);
        exp_t e;
        mbuf = {mbuf[27:0], kmap[r*4+c]};
        e.code = kmap[r*4+c];
        e.digs = mbuf;
        sb.push_back(e);
    endtask

    task automatic wait_held(input logic v, input string nm);
        int n;
        n = 0;
        while (key_held !== v && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 32'(key_held), 32'(v));
    endtask

    task automatic wait_col(input logic [3:0] v, input string nm);
        int n;
        n = 0;
        while (col !== v && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 32'(col), 32'(v));
    endtask

    task automatic press(input int r, input int c, input int hold);
        expect_key(r, c);
        key_r  = 2'(r);
        key_c  = 2'(c);
        key_dn = 1'b1;
        wait_held(1'b1, "press_held");
        repeat (hold) @(negedge clk);
        key_dn = 1'b0;
        wait_held(1'b0, "release_done");
    endtask

    initial begin
        int         n;
        logic [3:0] ec;
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        clear  = 1'b0;
        key_dn = 1'b0;
        key_r  = 2'd0;
        key_c  = 2'd0;
        ovr_en = 1'b0;
        ovr    = 4'hF;
        mbuf   = '0;
        kmap   = '{4'h1, 4'h2, 4'h3, 4'hA,
                   4'h4, 4'h5, 4'h6, 4'hB,
                   4'h7, 4'h8, 4'h9, 4'hC,
                   4'h0, 4'hF, 4'hE, 4'hD};

        // 1: reset state and idle column rotation
        repeat (3) @(negedge clk);
        chk("rst_col", 32'(col), 32'h0000_000E);
        chk("rst_valid", 32'(key_valid), 32'h0);
        chk("rst_code", 32'(key_code), 32'h0);
        chk("rst_held", 32'(key_held), 32'h0);
        chk("rst_digits", dut_digs, 32'h0);
        reset = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            ec = ~(4'b0001 << ((k / 4) % 4));
            chk("scan_col", 32'(col), 32'(ec));
        end
        chk("idle_digits", dut_digs, 32'h0);

        // 2: key "5", release latency = 2 sync + 1 detect + 3 debounce
        expect_key(1, 1);
        key_r  = 2'd1;
        key_c  = 2'd1;
        key_dn = 1'b1;
        wait_held(1'b1, "five_held");
        repeat (20) @(negedge clk);
        key_dn = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (key_held && n < 50);
        chk("release_latency", 32'(n), 32'd6);
        chk("resume_col", 32'(col), 32'h0000_000B);

        // 3: "1", "A", "0" then nine "7"
        press(0, 0, 5);
        press(0, 3, 5);
        press(3, 0, 5);
        chk("three_keys", dut_digs, 32'h0000_51A0);
        for (int k = 0; k < 9; k++) begin
            press(2, 0, 3);
        end
        chk("all_sevens", dut_digs, 32'h7777_7777);

        // 4: two-clock glitch on row0 in column 0
        wait_col(4'b0111, "sync_c3");
        wait_col(4'b1110, "sync_c0");
        ovr    = 4'b1110;
        ovr_en = 1'b1;
        repeat (2) @(negedge clk);
        ovr_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("glitch_frozen", 32'(col), 32'h0000_000E);
        @(negedge clk);
        chk("glitch_advance", 32'(col), 32'h0000_000D);
        chk("glitch_held", 32'(key_held), 32'h0);

        // 5a: rows 0 and 2 low together are ignored
        wait_col(4'b0111, "sync_c3b");
        wait_col(4'b1110, "sync_c0b");
        ovr    = 4'b1010;
        ovr_en = 1'b1;
        repeat (4) @(negedge clk);
        chk("ghost_col1", 32'(col), 32'h0000_000D);
        repeat (4) @(negedge clk);
        chk("ghost_col2", 32'(col), 32'h0000_000B);
        ovr_en = 1'b0;
        chk("ghost_held", 32'(key_held), 32'h0);

        // 5b: "D" with a one-clock bounce during release
        expect_key(3, 3);
        key_r  = 2'd3;
        key_c  = 2'd3;
        key_dn = 1'b1;
        wait_held(1'b1, "d_held");
        repeat (5) @(negedge clk);
        key_dn = 1'b0;
        repeat (3) @(negedge clk);
        key_dn = 1'b1;
        @(negedge clk);
        key_dn = 1'b0;
        repeat (3) @(negedge clk);
        chk("bounce_held", 32'(key_held), 32'h1);
        wait_held(1'b0, "d_released");

        // 6: clear during the accept of "9"
        mbuf = '0;
        sb.push_back('{code: 4'h9, digs: 32'h0});
        clear  = 1'b1;
        key_r  = 2'd2;
        key_c  = 2'd2;
        key_dn = 1'b1;
        n = 0;
        while (key_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        clear = 1'b0;
        chk("nine_pulse", 32'(key_valid), 32'h1);
        chk("clear_wins", dut_digs, 32'h0);
        repeat (3) @(negedge clk);
        chk("nine_held", 32'(key_held), 32'h1);

        // 6: reset while held, key re-accepted once
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst2_col", 32'(col), 32'h0000_000E);
        chk("rst2_digits", dut_digs, 32'h0);
        chk("rst2_held", 32'(key_held), 32'h0);
        chk("rst2_code", 32'(key_code), 32'h0);
        mbuf = '0;
        expect_key(2, 2);
        reset = 1'b0;
        wait_held(1'b1, "reaccept_held");
        repeat (5) @(negedge clk);
        key_dn = 1'b0;
        wait_held(1'b0, "reaccept_released");

        repeat (20) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
